// File: rtl/lsu_store_tracker_if.sv
// Store-tracker bus: LSU store request/ack observation, issue-stage fence
// handshake and the pending-store status levels.
// Master = LSU / issue stage side, slave = lsu_store_tracker.

`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif

interface lsu_store_tracker_if #(
    parameter int NUM_WARPS = `NUM_WARPS
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    // Store request stream (tracker may back-pressure)
    logic                st_req_valid;
    logic [NW_WIDTH-1:0] st_req_wid;
    logic                st_req_ready;

    // Store acknowledge stream (always accepted)
    logic                st_ack_valid;
    logic [NW_WIDTH-1:0] st_ack_wid;

    // Fence / drain handshake
    logic                fence_valid;
    logic [NW_WIDTH-1:0] fence_wid;
    logic                fence_ready;
    logic                fence_done;
    logic [NW_WIDTH-1:0] fence_done_wid;

    // Status levels towards the issue stage
    logic [NUM_WARPS-1:0] pending_mask;
    logic                 no_pending_stores;

    modport master (
        output st_req_valid, st_req_wid,
        output st_ack_valid, st_ack_wid,
        output fence_valid, fence_wid,
        input  st_req_ready, fence_ready, fence_done, fence_done_wid,
        input  pending_mask, no_pending_stores
    );

    modport slave (
        input  st_req_valid, st_req_wid,
        input  st_ack_valid, st_ack_wid,
        input  fence_valid, fence_wid,
        output st_req_ready, fence_ready, fence_done, fence_done_wid,
        output pending_mask, no_pending_stores
    );
endinterface

// File: rtl/lsu_store_tracker.sv
// lsu_store_tracker: counts stores issued to memory but not yet acknowledged,
// per warp and in total, drives the no-pending-stores level for the issue
// stage and serves a per-warp fence/drain handshake.
// Optional drain watchdog: define LSU_STORE_TIMEOUT_EN to add the sticky
// drain_timeout output.

`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif

module lsu_store_tracker #(
    parameter int NUM_WARPS      = `NUM_WARPS,
    parameter int MAX_PENDING    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    lsu_store_tracker_if.slave  bus
`ifdef LSU_STORE_TIMEOUT_EN
    ,
    output logic                drain_timeout
`endif
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int CW       = $clog2(MAX_PENDING + 1);
    localparam int TW       = $clog2(NUM_WARPS * MAX_PENDING + 1);

    // Reject configurations that cannot work at elaboration time
    if (MAX_PENDING < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lsu_store_tracker: MAX_PENDING and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_DONE
    } state_e;

    logic [CW-1:0]       cnt_q [NUM_WARPS];
    logic [CW-1:0]       cnt_d [NUM_WARPS];
    logic [TW-1:0]       total_q, total_d;
    logic                fire;
    logic                ack_ok;
    state_e              state_q, state_d;
    logic [NW_WIDTH-1:0] drain_wid_q, drain_wid_d;

    // A warp at its limit refuses further stores; acks to an empty warp are dropped
    assign bus.st_req_ready = (cnt_q[bus.st_req_wid] != CW'(MAX_PENDING));
    assign fire             = bus.st_req_valid && bus.st_req_ready;
    assign ack_ok           = bus.st_ack_valid && (cnt_q[bus.st_ack_wid] != '0);

    // Presenting a store already counts as "not empty" so atomics never slip past it
    assign bus.no_pending_stores = (total_q == '0) && !bus.st_req_valid;

    // Next-state of per-warp and total counters; fire+ack to one warp nets zero
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        total_d = total_q + TW'(fire) - TW'(ack_ok);
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_d[w] = cnt_q[w];
            if (fire && bus.st_req_wid == NW_WIDTH'(w)) begin
                cnt_d[w] = cnt_d[w] + CW'(1);
            end
            if (ack_ok && bus.st_ack_wid == NW_WIDTH'(w)) begin
                cnt_d[w] = cnt_d[w] - CW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        // NOTE: the counter array is small and drives ready/status directly, so every entry is reset explicitly.
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= '0;
            end
            total_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    // Per-warp busy bits straight from the registered counters
    always_comb begin
        bus.pending_mask = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            bus.pending_mask[w] = (cnt_q[w] != '0);
        end
    end

    // Fence FSM next-state and outputs
    always_comb begin
        state_d            = state_q;
        drain_wid_d        = drain_wid_q;
        bus.fence_ready    = 1'b0;
        bus.fence_done     = 1'b0;
        bus.fence_done_wid = '0;
        unique case (state_q)
            S_IDLE: begin
                bus.fence_ready = 1'b1;
                if (bus.fence_valid) begin
                    drain_wid_d = bus.fence_wid;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stores to the drained warp keep being counted; wait for true zero
                if (cnt_q[drain_wid_q] == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.fence_done     = 1'b1;
                bus.fence_done_wid = drain_wid_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fence FSM state register; reset discards any fence in progress
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            drain_wid_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_wid_q <= drain_wid_d;
        end
    end

`ifdef LSU_STORE_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    // Watchdog: counts DRAIN cycles, restarts on each accepted fence, flag is sticky
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_q == S_IDLE && bus.fence_valid) begin
            wd_d = '0;
        end else if (state_q == S_DRAIN && wd_q != '1) begin
            wd_d = wd_q + 32'd1;
        end
        if (state_q == S_DRAIN && wd_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign drain_timeout = timeout_q;
`endif

    // An ack for a warp with nothing outstanding indicates a lost or duplicated response
    a_no_ack_underflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(bus.st_ack_valid && cnt_q[bus.st_ack_wid] == '0)
    );

endmodule

// File: doc/lsu_store_tracker.md
Name: lsu_store_tracker

Overview:
- Counts store requests the LSU has issued to memory but that memory has not yet acknowledged, per warp and in total.
- Produces the no-pending-stores level that the issue stage consumes to hold back atomics.
- Serves a per-warp fence/drain handshake.
- Sits in the LSU, directly upstream of the issue stage, and observes the LSU memory request and response streams.

Parameters:
- NUM_WARPS, `NUM_WARPS: number of warps tracked.
- MAX_PENDING, 16: maximum outstanding stores per warp. Must be ≥1.
- TIMEOUT_CYCLES, 4096: drain watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset: asserted when 0, sampled on the rising edge of clk.
- st_req_valid  in  1  a store is being presented to memory.
- st_req_wid  in  NW_WIDTH  warp of the store.
- st_req_ready  out  1  tracker can accept the store.
- st_ack_valid  in  1  a memory store acknowledge is returning. Always accepted.
- st_ack_wid  in  NW_WIDTH  warp of the acknowledge.
- fence_valid  in  1  drain request from the issue stage.
- fence_wid  in  NW_WIDTH  warp to drain.
- fence_ready  out  1  fence request accepted.
- fence_done  out  1  one-cycle pulse when the drain completes.
- fence_done_wid  out  NW_WIDTH  warp whose drain completed.
- pending_mask  out  NUM_WARPS  bit w set iff warp w has a nonzero count.
- no_pending_stores  out  1  no stores outstanding for any warp.
- drain_timeout  out  1  sticky watchdog flag. Present only with the optional feature.

Behaviour:
- Handshakes and counters:
  - A store fire is st_req_valid && st_req_ready.
  - st_req_ready = (cnt[st_req_wid] != MAX_PENDING). This is combinational from registered state.
  - Per-warp counter width is clog2(MAX_PENDING+1). Total counter width is clog2(NUM_WARPS*MAX_PENDING+1).
  - Each cycle: cnt[w] += (fire && st_req_wid==w), and cnt[w] -= (st_ack_valid && st_ack_wid==w).
  - A fire and an ack to the same warp in the same cycle give net zero. The total counter follows the same rule.
  - An ack to a warp whose counter is 0 is ignored (counter holds at 0) and raises a simulation assertion.
- no_pending_stores = (total==0) && !st_req_valid.
  - It drops in the same cycle a store is presented, so the issue stage never sees a false "empty".
  - It rises in the cycle after the last ack.
- pending_mask is combinational from the registered counters.
- Fence FSM, states IDLE, DRAIN, DONE:
  - IDLE: fence_ready=1. On fence_valid, capture fence_wid into drain_wid and go to DRAIN.
  - DRAIN: fence_ready=0. When the registered cnt[drain_wid]==0, go to DONE. Stores and acks continue to be counted normally, including stores from drain_wid.
  - DONE: fence_done=1 and fence_done_wid=drain_wid for exactly one cycle, then go to IDLE. fence_ready=0.
  - Minimum latency: fence accepted at cycle 0 with an empty warp, fence_done at cycle 2.
  - A fence presented while the FSM is not in IDLE is stalled via fence_ready=0.
- Reset values (reset==0 on a clock edge):
  - All counters 0; FSM in IDLE; drain_wid 0.
  - Outputs: fence_done=0, fence_done_wid=0, pending_mask=0, fence_ready=1, st_req_ready=1.
  - no_pending_stores=1 when st_req_valid=0.
  - drain_timeout=0.
- Reset asserted mid-drain discards the fence. No fence_done is produced, and in-flight acks arriving after reset are ignored per the underflow rule.

Optional Feature:
- Macro: LSU_STORE_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles spent in DRAIN and clears on entering DRAIN.
  - When it reaches TIMEOUT_CYCLES, drain_timeout sets and stays set until reset.
  - The FSM continues to wait; it does not abort the drain.
- Undefined: no watchdog logic and no drain_timeout port.

Test Plan:
- Reset, then idle → no_pending_stores=1, pending_mask=0, fence_ready=1, st_req_ready=1.
- Warp 2: fire 3 stores on cycles 1–3, return 3 acks on cycles 10–12 → pending_mask[2]=1 from cycle 2 through 12, no_pending_stores=0 from cycle 1 and back to 1 at cycle 13.
- Fire and ack for warp 1 in the same cycle with cnt[1]=1 → cnt[1] stays 1 and no_pending_stores stays 0.
- 16 stores to warp 0 with MAX_PENDING=16 → st_req_ready=0 for warp 0, warp 3 still accepted; one ack to warp 0 → st_req_ready for warp 0 returns to 1 the next cycle.
- Fence on warp 4 with 2 outstanding stores, acks at cycles 5 and 8 → fence_done pulses at cycle 10 with fence_done_wid=4; a second fence at cycle 3 sees fence_ready=0.
- With LSU_STORE_TIMEOUT_EN and TIMEOUT_CYCLES=8, fence on a warp with no acks → drain_timeout=1 after 8 DRAIN cycles; it persists and clears only on reset.
